// File: rtl/hazard_detect.sv
// hazard_detect: load-use stall and forwarding-select generator for the IF/ID/EX/WB pipeline.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cycles counter port.
module hazard_detect #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        rs1_hazard,
  output logic [1:0]        rs2_hazard
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] LSTALL = 1'b1;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_RESULT = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;

  if (CNT_W == 0 || REG_AW == 0) begin : g_cfg_check
    $error("hazard_detect: REG_AW and CNT_W must be nonzero");
  end

  logic [0:0]        state;
  logic [0:0]        state_nxt;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  logic              rs1_ex_hit;
  logic              rs2_ex_hit;
  logic              rs1_wb_hit;
  logic              rs2_wb_hit;
  logic              load_use;
  logic              advance;
  logic [1:0]        rs1_code;
  logic [1:0]        rs2_code;

  function automatic logic src_match(input logic              uses,
                                     input logic              slot_valid,
                                     input logic              slot_regwrite,
                                     input logic [REG_AW-1:0] slot_rd,
                                     input logic [REG_AW-1:0] src);
    return uses & slot_valid & slot_regwrite & (slot_rd == src) & (src != '0);
  endfunction

  // Distance-1 ALU result wins over the distance-2 writeback value.
  function automatic logic [1:0] fwd_code(input logic ex_hit,
                                          input logic ex_load,
                                          input logic wb_hit);
    if (ex_hit && !ex_load) return FWD_RESULT;
    if (wb_hit)             return FWD_MEM;
    return FWD_NONE;
  endfunction

  // Next-state, stall and forwarding-code decode.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    rs1_ex_hit = src_match(id_uses_rs1, ex_valid, ex_regwrite, ex_rd, id_rs1_addr);
    rs2_ex_hit = src_match(id_uses_rs2, ex_valid, ex_regwrite, ex_rd, id_rs2_addr);
    rs1_wb_hit = src_match(id_uses_rs1, wb_valid, wb_regwrite, wb_rd, id_rs1_addr);
    rs2_wb_hit = src_match(id_uses_rs2, wb_valid, wb_regwrite, wb_rd, id_rs2_addr);
    load_use   = ex_memread & (rs1_ex_hit | rs2_ex_hit);

    case (state)
      RUN: begin
        stall = id_valid & ~flush & load_use;
        if (stall) state_nxt = LSTALL;
      end
      default: state_nxt = RUN;
    endcase

    advance  = id_valid & ~stall & ~flush;
    rs1_code = fwd_code(rs1_ex_hit, ex_memread, rs1_wb_hit);
    rs2_code = fwd_code(rs2_ex_hit, ex_memread, rs2_wb_hit);
  end

  // Tracker slots, FSM state and registered EX-stage controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      bubble      <= 1'b0;
      rs1_hazard  <= FWD_NONE;
      rs2_hazard  <= FWD_NONE;
    end else begin
      state       <= state_nxt;
      ex_valid    <= advance;
      ex_rd       <= id_rd_addr;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      wb_valid    <= ex_valid;
      wb_rd       <= ex_rd;
      wb_regwrite <= ex_regwrite;
      bubble      <= stall | flush;
      rs1_hazard  <= advance ? rs1_code : FWD_NONE;
      rs2_hazard  <= advance ? rs2_code : FWD_NONE;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Directed vector bench for hazard_detect: one row per ID cycle, stall checked before the
// edge, bubble/codes (and stall_cycles when HAZARD_STALL_CNT_EN is defined) after it.
module tb_hazard_detect;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [1:0]        rs1_hazard;
  logic [1:0]        rs2_hazard;
  logic [CNT_W-1:0]  stall_cycles;

  hazard_detect #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd_addr  (id_rd_addr),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .bubble      (bubble),
    .rs1_hazard  (rs1_hazard),
    .rs2_hazard  (rs2_hazard)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

`ifndef HAZARD_STALL_CNT_EN
  assign stall_cycles = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              v;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
    logic              fl;
    logic              e_stall;
    logic              e_bub;
    logic [1:0]        e_h1;
    logic [1:0]        e_h2;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input int rst, input int v, input int rs1, input int rs2,
                              input int u1, input int u2, input int rd, input int rw,
                              input int mr, input int fl, input int es, input int eb,
                              input int h1, input int h2, input int ec);
    vec_t t;
    t.rst = 1'(rst);  t.v  = 1'(v);
    t.rs1 = REG_AW'(rs1); t.rs2 = REG_AW'(rs2);
    t.u1  = 1'(u1);   t.u2 = 1'(u2);
    t.rd  = REG_AW'(rd);
    t.rw  = 1'(rw);   t.mr = 1'(mr);  t.fl = 1'(fl);
    t.e_stall = 1'(es); t.e_bub = 1'(eb);
    t.e_h1 = 2'(h1);  t.e_h2 = 2'(h2);
    t.e_cnt = CNT_W'(ec);
    return t;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst_n       = t.rst;
    id_valid    = t.v;
    id_rs1_addr = t.rs1;
    id_rs2_addr = t.rs2;
    id_uses_rs1 = t.u1;
    id_uses_rs2 = t.u2;
    id_rd_addr  = t.rd;
    id_regwrite = t.rw;
    id_memread  = t.mr;
    flush       = t.fl;
    #1;
    check("stall", idx, int'(stall), int'(t.e_stall));
    @(posedge clk);
    #1;
    check("bubble", idx, int'(bubble), int'(t.e_bub));
    check("rs1_hazard", idx, int'(rs1_hazard), int'(t.e_h1));
    check("rs2_hazard", idx, int'(rs2_hazard), int'(t.e_h2));
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cycles", idx, int'(stall_cycles), int'(t.e_cnt));
`endif
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd_addr = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;

    //              rst v rs1 rs2 u1 u2 rd rw mr fl | stall bub h1 h2 cnt
    vecs.push_back(mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1,  2, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 0)); // add x5,x1,x2
    vecs.push_back(mk(1, 1,  5,  7, 1, 1,  6, 1, 0, 0,  0, 0, 1, 0, 0)); // sub x6,x5,x7
    vecs.push_back(mk(1, 1,  1,  2, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 0)); // add x5,x1,x2
    vecs.push_back(mk(1, 1,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0)); // nop
    vecs.push_back(mk(1, 1,  1,  5, 1, 1,  8, 1, 0, 0,  0, 0, 0, 2, 0)); // or x8,x1,x5
    vecs.push_back(mk(1, 1,  1,  0, 1, 0,  9, 1, 1, 0,  0, 0, 0, 0, 0)); // lw x9,0(x1)
    vecs.push_back(mk(1, 1,  9,  9, 1, 1, 10, 1, 0, 0,  1, 1, 0, 0, 1)); // add x10,x9,x9 stalls
    vecs.push_back(mk(1, 1,  9,  9, 1, 1, 10, 1, 0, 0,  0, 0, 2, 2, 1)); // held, advances
    vecs.push_back(mk(1, 1,  1,  2, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0, 1)); // add x0,x1,x2
    vecs.push_back(mk(1, 1,  0,  0, 1, 1, 11, 1, 0, 0,  0, 0, 0, 0, 1)); // add x11,x0,x0
    vecs.push_back(mk(1, 1,  1,  2, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 1)); // add x5,x1,x2
    vecs.push_back(mk(1, 1,  5,  3, 1, 1,  5, 1, 0, 0,  0, 0, 1, 0, 1)); // add x5,x5,x3
    vecs.push_back(mk(1, 1,  5,  5, 1, 1, 12, 1, 0, 0,  0, 0, 1, 1, 1)); // add x12,x5,x5
    vecs.push_back(mk(1, 1,  2,  0, 1, 0, 13, 1, 1, 0,  0, 0, 0, 0, 1)); // lw x13,0(x2)
    vecs.push_back(mk(1, 1, 13,  1, 1, 1, 14, 1, 0, 1,  0, 1, 0, 0, 1)); // flush beats stall
    vecs.push_back(mk(1, 1, 13,  0, 1, 0, 16, 1, 1, 0,  0, 0, 2, 0, 1)); // lw x16,0(x13)
    vecs.push_back(mk(1, 1, 16,  0, 1, 1, 17, 1, 0, 0,  1, 1, 0, 0, 2)); // add x17,x16,x0 stalls
    vecs.push_back(mk(0, 1, 16,  0, 1, 1, 17, 1, 0, 0,  0, 0, 0, 0, 0)); // reset in LSTALL
    vecs.push_back(mk(1, 1, 16,  0, 1, 1, 17, 1, 0, 0,  0, 0, 0, 0, 0)); // no stale forward
    vecs.push_back(mk(1, 1,  2,  0, 1, 0,  1, 1, 1, 0,  0, 0, 0, 0, 0)); // lw x1,0(x2)
    vecs.push_back(mk(1, 1,  1,  0, 1, 0,  2, 1, 1, 0,  1, 1, 0, 0, 1)); // lw x2,0(x1) stalls
    vecs.push_back(mk(1, 1,  1,  0, 1, 0,  2, 1, 1, 0,  0, 0, 2, 0, 1));
    vecs.push_back(mk(1, 1,  2,  2, 1, 1,  3, 1, 0, 0,  1, 1, 0, 0, 2)); // add x3,x2,x2 stalls
    vecs.push_back(mk(1, 1,  2,  2, 1, 1,  3, 1, 0, 0,  0, 0, 2, 2, 2));
    vecs.push_back(mk(1, 1,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 2)); // nop
    vecs.push_back(mk(1, 1,  0,  0, 1, 0,  4, 1, 1, 0,  0, 0, 0, 0, 2)); // lw x4,0(x0)
    vecs.push_back(mk(1, 1,  4,  0, 1, 1,  5, 1, 0, 0,  1, 1, 0, 0, 3)); // add x5,x4,x0 stalls
    vecs.push_back(mk(1, 1,  4,  0, 1, 1,  5, 1, 0, 0,  0, 0, 2, 0, 3));
    vecs.push_back(mk(1, 1,  5,  0, 1, 0,  6, 1, 1, 0,  0, 0, 1, 0, 3)); // lw x6,0(x5)
    vecs.push_back(mk(1, 1,  0,  6, 1, 1,  7, 1, 0, 0,  1, 1, 0, 0, 3)); // rs2-only load-use, saturate
    vecs.push_back(mk(1, 1,  0,  6, 1, 1,  7, 1, 0, 0,  0, 0, 0, 2, 3));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Flush arriving in LSTALL cancels the held instruction and the FSM keeps running.
    apply(mk(1, 1,  1, 0, 1, 0, 20, 1, 1, 0,  0, 0, 0, 0, 3), 100); // lw x20,0(x1)
    apply(mk(1, 1, 20, 20, 1, 1, 21, 1, 0, 0,  1, 1, 0, 0, 3), 101); // add x21 stalls
    apply(mk(1, 1, 20, 20, 1, 1, 21, 1, 0, 1,  0, 1, 0, 0, 3), 102); // flush in LSTALL
    apply(mk(1, 1,  0, 0, 1, 0, 22, 1, 1, 0,  0, 0, 0, 0, 3), 103); // lw x22,0(x0)
    apply(mk(1, 1, 22, 0, 1, 1, 23, 1, 0, 0,  1, 1, 0, 0, 3), 104); // stalls again from RUN
    apply(mk(1, 1, 22, 0, 1, 1, 23, 1, 0, 0,  0, 0, 2, 0, 3), 105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
